// File: rtl/rmw_sequencer.sv
// -----------------------------------------------------------------------------
// rmw_sequencer
//   Sequences 65C816 read-modify-write memory instructions around an external
//   combinational ALU. Reads an 8- or 16-bit operand over a byte-wide request/
//   acknowledge bus, holds the ALU controls stable for the modify cycle,
//   captures result and N/Z/C, writes the result back high byte first, then
//   pulses done/flags_we for one cycle.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   start                    launch request, sampled only when idle
//   fst_op, sec_op, fc, w16  ALU controls / operand width, latched at start
//   emul, wrap16, addr, acc  mode, address wrap, operand address, accumulator
//   mem_*                    byte-wide bus (req/we/addr/wdata out, rdata/ack in)
//   alu_l, alu_r, alu_*      ALU operands and latched controls
//   alu_res, alu_co/zo/so    ALU result and flags
//   busy, done, flags_we     status; done and flags_we are one-cycle pulses
//   n_out, z_out, c_out      captured flags
//   res_out                  captured result (high byte 0 for 8-bit ops)
// -----------------------------------------------------------------------------
module rmw_sequencer #(
  parameter int ADDR_W    = 24,
  parameter bit EMU_DUMMY = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [2:0]        fst_op,
  input  logic [2:0]        sec_op,
  input  logic              fc,
  input  logic              w16,
  input  logic              emul,
  input  logic              wrap16,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       acc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       alu_l,
  output logic [15:0]       alu_r,
  output logic [2:0]        alu_fst_op,
  output logic [2:0]        alu_sec_op,
  output logic              alu_fc,
  output logic              alu_w16,
  input  logic [15:0]       alu_res,
  input  logic              alu_co,
  input  logic              alu_zo,
  input  logic              alu_so,
  output logic              busy,
  output logic              done,
  output logic              flags_we,
  output logic              n_out,
  output logic              z_out,
  output logic              c_out,
  output logic [15:0]       res_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_MODIFY, S_WR_HI, S_WR_LO, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          fst_q, fst_d, sec_q, sec_d;
  logic                fc_q, fc_d, w16_q, w16_d, emul_q, emul_d, wrap_q, wrap_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         acc_q, acc_d, res_q, res_d;
  logic [7:0]          lo_q, lo_d, hi_q, hi_d;
  logic                n_q, n_d, z_q, z_d, c_q, c_d;
  logic                req_q, req_d, we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [7:0]          wdata_q, wdata_d;

  // High-byte address: either a full-width increment or one confined to the
  // low 16 bits (bank wrap).
  function automatic logic [ADDR_W-1:0] hi_addr(input logic [ADDR_W-1:0] a,
                                                input logic wrap);
    logic [ADDR_W-1:0] r;
    if (wrap) begin
      r       = a;
      r[15:0] = a[15:0] + 16'd1;
    end else begin
      r = a + ADDR_W'(1);
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    fst_d   = fst_q;   sec_d  = sec_q;  fc_d   = fc_q;
    w16_d   = w16_q;   emul_d = emul_q; wrap_d = wrap_q;
    addr_d  = addr_q;  acc_d  = acc_q;
    lo_d    = lo_q;    hi_d   = hi_q;   res_d  = res_q;
    n_d     = n_q;     z_d    = z_q;    c_d    = c_q;

    case (state_q)
      S_IDLE: if (start) begin
        fst_d  = fst_op; sec_d  = sec_op; fc_d   = fc;
        w16_d  = w16;    emul_d = emul;   wrap_d = wrap16;
        addr_d = addr;   acc_d  = acc;
        lo_d   = 8'h00;  hi_d   = 8'h00;  // hi stays 0 for 8-bit operands
        state_d = S_RD_LO;
      end
      S_RD_LO: if (mem_ack) begin
        lo_d    = mem_rdata;
        state_d = w16_q ? S_RD_HI : S_MODIFY;
      end
      S_RD_HI: if (mem_ack) begin
        hi_d    = mem_rdata;
        state_d = S_MODIFY;
      end
      S_MODIFY: begin
        // ALU inputs come from registers, so capturing every modify cycle is
        // harmless while a dummy write is stalled.
        res_d = w16_q ? alu_res : {8'h00, alu_res[7:0]};
        n_d   = alu_so;
        z_d   = alu_zo;
        c_d   = alu_co;
        // Without the dummy write mem_req is low here, so ack is ignored.
        if (!(EMU_DUMMY && emul_q) || mem_ack)
          state_d = w16_q ? S_WR_HI : S_WR_LO;
      end
      S_WR_HI: if (mem_ack) state_d = S_WR_LO;
      S_WR_LO: if (mem_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered: decode them from the state being entered so
    // they are valid in the first cycle of that state and stable until ack.
    req_d   = 1'b0;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    case (state_d)
      S_RD_LO: begin req_d = 1'b1; maddr_d = addr_d; end
      S_RD_HI: begin req_d = 1'b1; maddr_d = hi_addr(addr_d, wrap_d); end
      S_MODIFY: if (EMU_DUMMY && emul_d) begin
        req_d = 1'b1; we_d = 1'b1; maddr_d = addr_d; wdata_d = lo_d;
      end
      S_WR_HI: begin
        req_d = 1'b1; we_d = 1'b1;
        maddr_d = hi_addr(addr_d, wrap_d); wdata_d = res_d[15:8];
      end
      S_WR_LO: begin
        req_d = 1'b1; we_d = 1'b1; maddr_d = addr_d; wdata_d = res_d[7:0];
      end
      default: ;
    endcase
    done_d = (state_d == S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      fst_q <= 3'd0;  sec_q  <= 3'd0; fc_q   <= 1'b0;
      w16_q <= 1'b0;  emul_q <= 1'b0; wrap_q <= 1'b0;
      addr_q <= '0;   acc_q  <= 16'h0;
      lo_q  <= 8'h00; hi_q   <= 8'h00; res_q <= 16'h0;
      n_q   <= 1'b0;  z_q    <= 1'b0;  c_q   <= 1'b0;
      req_q <= 1'b0;  we_q   <= 1'b0;  done_q <= 1'b0;
      maddr_q <= '0;  wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      fst_q <= fst_d;  sec_q  <= sec_d;  fc_q   <= fc_d;
      w16_q <= w16_d;  emul_q <= emul_d; wrap_q <= wrap_d;
      addr_q <= addr_d; acc_q <= acc_d;
      lo_q  <= lo_d;   hi_q   <= hi_d;   res_q <= res_d;
      n_q   <= n_d;    z_q    <= z_d;    c_q   <= c_d;
      req_q <= req_d;  we_q   <= we_d;   done_q <= done_d;
      maddr_q <= maddr_d; wdata_q <= wdata_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign alu_l      = acc_q;
  assign alu_r      = {hi_q, lo_q};
  assign alu_fst_op = fst_q;
  assign alu_sec_op = sec_q;
  assign alu_fc     = fc_q;
  assign alu_w16    = w16_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign flags_we   = done_q;
  assign n_out      = n_q;
  assign z_out      = z_q;
  assign c_out      = c_q;
  assign res_out    = res_q;

endmodule
